// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master command port between N_REQ requesters.
// Latency: grant+start 1 cycle after request seen in IDLE; response 1 cycle after m_done.
// Backpressure: requesters hold req_valid until their req_ready pulse; one command in flight.
module axi_lite_cmd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_mode,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_start,
  output logic                      m_mode,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_done,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                m_mode_q, m_mode_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]    req_ready_q, req_ready_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                m_start_q, m_start_d;

  logic                found;
  logic [IDX_W-1:0]    pick;

  // Round-robin search starting just after the previous winner, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    pick  = last_q;
    idx   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    m_mode_d    = m_mode_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    m_start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_ISSUE;
          win_d       = pick;
          last_d      = pick;
          m_mode_d    = req_mode[pick];
          m_addr_d    = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          m_wdata_d   = req_wdata[int'(pick)*DATA_W +: DATA_W];
          req_ready_d = ONE << pick;
          m_start_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_rdata_d = m_mode_q ? '0 : m_rdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = ONE << win_q;
          state_d     = S_RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = ONE << win_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        // After a timeout the slave still owes us a done; absorb it before reissuing.
        state_d = rsp_err_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (m_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so an aborted command vanishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= LAST_RST;
      win_q       <= '0;
      m_mode_q    <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      m_start_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      m_mode_q    <= m_mode_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      m_start_q   <= m_start_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign m_start   = m_start_q;
  assign m_mode    = m_mode_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
module tb_axi_lite_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 20;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_mode;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            m_start;
  logic            m_mode;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_done;
  logic            busy;

  axi_lite_cmd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          idx;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ecmd_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } ersp_t;

  cmd_t  rq_mem [N][16];
  int    rq_wr [N];
  int    rq_rd [N];
  ecmd_t exp_cmd [$];
  ersp_t exp_rsp [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_start  = 0;
  int n_rsp    = 0;
  int start_cyc = 0;
  int rsp_cyc   = 0;
  int done_cyc  = 0;

  // slave model state
  logic [31:0] mem [64];
  bit          hang = 1'b0;
  int          force_req = 0;
  int          force_ack = 0;
  bit          slv_busy = 1'b0;
  int          slv_cnt = 0;
  logic        slv_mode = 1'b0;
  logic [31:0] slv_addr = '0;
  logic [31:0] slv_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: each presents its queue head and advances on its req_ready.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) rq_rd[i] = rq_wr[i];
      else if (req_ready[i]) rq_rd[i] = rq_rd[i] + 1;
      if (rq_rd[i] < rq_wr[i]) begin
        req_valid[i]            = 1'b1;
        req_mode[i]             = rq_mem[i][rq_rd[i]].mode;
        req_addr[i*AW +: AW]    = rq_mem[i][rq_rd[i]].addr;
        req_wdata[i*DW +: DW]   = rq_mem[i][rq_rd[i]].wdata;
      end else begin
        req_valid[i]            = 1'b0;
        req_mode[i]             = 1'b0;
        req_addr[i*AW +: AW]    = '0;
        req_wdata[i*DW +: DW]   = '0;
      end
    end
  end

  // Slave model: done a few cycles after start; garbage on m_rdata for writes/forced dones.
  always @(negedge clk) begin
    m_done  = 1'b0;
    m_rdata = 32'hBAD0BAD0;
    if (rst) slv_busy = 1'b0;
    if (force_req != force_ack) begin
      force_ack = force_req;
      m_done    = 1'b1;
      m_rdata   = 32'h12345678;
      done_cyc  = cyc;
    end else if (slv_busy) begin
      if (slv_cnt == 0) begin
        m_done   = 1'b1;
        done_cyc = cyc;
        slv_busy = 1'b0;
        if (slv_mode) begin
          mem[slv_addr[7:2]] = slv_wdata;
          m_rdata = 32'hFEEDFACE;
        end else begin
          m_rdata = mem[slv_addr[7:2]];
        end
      end else begin
        slv_cnt--;
      end
    end
    if (m_start && !rst) begin
      slv_busy  = !hang;
      slv_mode  = m_mode;
      slv_addr  = m_addr;
      slv_wdata = m_wdata;
      slv_cnt   = 2 + int'(m_addr[3:2]);
    end
  end

  // Monitor: pops the scoreboard on every grant and every response.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_start) begin
        n_start++;
        start_cyc = cyc;
        if (exp_cmd.size() == 0) begin
          chk("unexpected_start", 64'(m_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ecmd_t e;
          e = exp_cmd.pop_front();
          chk("grant_onehot", 64'(req_ready), 64'(1) << e.idx);
          chk("m_mode", 64'(m_mode), 64'(e.mode));
          chk("m_addr", 64'(m_addr), 64'(e.addr));
          chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
        end
      end else if (req_ready != '0) begin
        chk("ready_without_start", 64'(req_ready), 64'd0);
      end
      if (rsp_valid != '0) begin
        n_rsp++;
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          ersp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(1) << r.idx);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(r.err));
          if (!r.err) chk("rsp_latency", 64'(cyc - done_cyc), 64'd1);
        end
      end
    end
  end

  task automatic issue(input int idx, input logic mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    ecmd_t e;
    ersp_t r;
    rq_mem[idx][rq_wr[idx]].mode  = mode;
    rq_mem[idx][rq_wr[idx]].addr  = addr;
    rq_mem[idx][rq_wr[idx]].wdata = wdata;
    rq_wr[idx] = rq_wr[idx] + 1;
    e.idx = idx; e.mode = mode; e.addr = addr; e.wdata = wdata;
    r.idx = idx; r.rdata = rdata; r.err = err;
    exp_cmd.push_back(e);
    exp_rsp.push_back(r);
  endtask

  task automatic wait_done(input string what, input bit need_idle);
    int t = 0;
    while ((exp_cmd.size() != 0 || exp_rsp.size() != 0 || (need_idle && busy)) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({"complete_", what}, 64'(t < 3000), 64'd1);
    @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_m_start"},   64'(m_start),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_m_mode"},    64'(m_mode),    64'd0);
    chk({tag, "_m_addr"},    64'(m_addr),    64'd0);
    chk({tag, "_m_wdata"},   64'(m_wdata),   64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < N; i++) begin rq_wr[i] = 0; rq_rd[i] = 0; end
    req_valid = '0; req_mode = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single write then read from requester 0
    issue(0, 1'b1, 32'h14, 32'hDDDDDDDD, 32'h0, 1'b0);
    wait_done("write0", 1'b1);
    issue(0, 1'b0, 32'h14, 32'h0, 32'hDDDDDDDD, 1'b0);
    wait_done("read0", 1'b1);

    // all four at once after reset: grants 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) issue(i, 1'b1, 32'(4*i), 32'(i), 32'h0, 1'b0);
    wait_done("all_write", 1'b1);
    for (int i = 0; i < N; i++) issue(i, 1'b0, 32'(4*i), 32'h0, 32'(i), 1'b0);
    wait_done("all_read", 1'b1);

    // requester 2 holds valid, requester 0 joins: 2,0,2,0
    begin
      int s0;
      int t;
      s0 = n_start;
      issue(2, 1'b1, 32'h20, 32'hA0, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h28, 32'hB0, 32'h0, 1'b0);
      issue(2, 1'b1, 32'h24, 32'hA1, 32'h0, 1'b0);
      issue(0, 1'b1, 32'h2C, 32'hB1, 32'h0, 1'b0);
      // hold requester 0's commands back until requester 2 is granted first
      rq_wr[0] = rq_wr[0] - 2;
      t = 0;
      while (n_start == s0 && t < 100) begin @(negedge clk); t++; end
      chk("rr_first_grant_seen", 64'(n_start > s0), 64'd1);
      rq_wr[0] = rq_wr[0] + 2;
      wait_done("fairness", 1'b1);
    end

    // hung slave: timeout error, then DRAIN until a forced done
    begin
      int s0;
      hang = 1'b1;
      issue(1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
      wait_done("timeout", 1'b0);
      chk("timeout_latency", 64'(rsp_cyc - start_cyc), 64'(TO + 2));
      s0 = n_start;
      issue(3, 1'b1, 32'h30, 32'h33, 32'h0, 1'b0);
      repeat (6) @(negedge clk);
      chk("busy_in_drain", 64'(busy), 64'd1);
      chk("no_issue_in_drain", 64'(n_start), 64'(s0));
      hang = 1'b0;
      force_req++;
      while (force_ack != force_req) @(negedge clk);
      while (cyc < done_cyc + 1) @(negedge clk);
      chk("idle_after_drain", 64'(busy), 64'd0);
      wait_done("after_drain", 1'b1);
    end

    // reset while a read from requester 0 sits in WAIT
    begin
      int s0;
      int t;
      hang = 1'b1;
      s0 = n_start;
      issue(0, 1'b0, 32'h14, 32'h0, 32'hDDDDDDDD, 1'b0);
      void'(exp_rsp.pop_back());
      t = 0;
      while (n_start == s0 && t < 100) begin @(negedge clk); t++; end
      chk("abort_read_started", 64'(n_start > s0), 64'd1);
      repeat (3) @(negedge clk);
      chk("busy_before_abort", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1 chk_zero_outputs("midreset");
      repeat (2) @(negedge clk);
      hang = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      issue(0, 1'b1, 32'h38, 32'hC0, 32'h0, 1'b0);
      issue(1, 1'b1, 32'h3C, 32'hC1, 32'h0, 1'b0);
      wait_done("post_reset", 1'b1);
    end

    // spurious done while idle
    begin
      int r0;
      r0 = n_rsp;
      force_req++;
      repeat (4) @(negedge clk);
      chk("spurious_busy", 64'(busy), 64'd0);
      chk("spurious_no_rsp", 64'(n_rsp), 64'(r0));
      issue(2, 1'b0, 32'h20, 32'h0, 32'hA0, 1'b0);
      wait_done("after_spurious", 1'b1);
    end

    chk("exp_cmd_empty", 64'(exp_cmd.size()), 64'd0);
    chk("exp_rsp_empty", 64'(exp_rsp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
# axi_lite_cmd_arbiter

- Round-robin arbiter sharing the single AXI-lite master command port (start/mode/addr/wdata_in, rdata_out/done) between N_REQ requesters.
- Sits between the requesting blocks and the AXI-lite master inside the top level.
- Serialises commands, steers each read-data result back to the issuing requester, and bounds every transaction with a timeout so that a hung slave cannot lock the bus.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before error (8-bit counter)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has a pending command; held until req_ready[i]
- req_mode  in  N_REQ  per-requester direction, 1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data, same packing
- req_ready  out  N_REQ  one-hot, one-cycle command-accept pulse
- rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and errors
- rsp_err  out  1  timeout flag, valid with rsp_valid
- m_start  out  1  one-cycle start pulse to the master
- m_mode  out  1  direction to the master
- m_addr  out  ADDR_W  address to the master
- m_wdata  out  DATA_W  write data to the master
- m_rdata  in  DATA_W  read data from the master, valid while m_done = 1
- m_done  in  1  one-cycle completion pulse from the master
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If any req_valid is set, select the winner round-robin. Search starts at (last_grant+1) mod N_REQ and wraps.
  - Latch the winner index, mode, addr and wdata into registers, set last_grant to the winner, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_start=1 and req_ready[winner]=1.
  - m_mode, m_addr and m_wdata drive the latched values.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - m_mode, m_addr and m_wdata stay stable.
  - On m_done=1: capture m_rdata if the latched mode is read, else capture 0. Set err=0 and go to RESP.
  - If m_done is low, increment the counter. When the counter reaches TIMEOUT: capture data=0, set err=1 and go to RESP.
- RESP (exactly 1 cycle):
  - rsp_valid[winner]=1, rsp_rdata=captured value, rsp_err=err.
  - If err=0, go to IDLE; if err=1, go to DRAIN.
- DRAIN:
  - Wait for the late m_done, discarding its data, then go to IDLE.
  - No new command is issued until it arrives.
- Fairness: a requester that keeps req_valid high is served at most once per N_REQ grants while others are requesting.
- A requester may raise req_valid again in the cycle after its own req_ready. It then competes normally.
- m_done arriving in IDLE, ISSUE or RESP is ignored.
- last_grant reset value = N_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - State = IDLE.
  - req_ready, rsp_valid, m_start, busy = 0.
  - rsp_rdata, rsp_err, m_mode, m_addr, m_wdata = 0.
  - Counter = 0.
- All outputs are registered or decoded from state registers only. No combinational path from req_valid or m_done to any output.
- Request seen in IDLE at edge k:
  - req_ready and m_start are high during cycle k+1.
  - WAIT begins at k+2.
- m_done sampled high in WAIT at edge j: rsp_valid is high during cycle j+1, and the block is back in IDLE at j+2.
- Minimum issue-to-issue spacing with master done latency D cycles after start: D+3 cycles.
- Timeout: rsp_err pulse occurs TIMEOUT+1 cycles after WAIT entry when m_done never arrives.
- Reset mid-transaction returns the block to IDLE immediately. Outputs clear asynchronously, and no rsp_valid is produced for the aborted command.

## Test plan
- Single write, then read from requester 0:
  - Write addr 0x14, wdata 0xDDDDDDDD: one req_ready[0] pulse, one m_start pulse, rsp_valid[0] with rsp_rdata=0 and rsp_err=0.
  - Read addr 0x14: rsp_rdata=0xDDDDDDDD.
- All four requesters assert simultaneously after reset, each writing its index to addr 4*i:
  - Grant order is 0,1,2,3.
  - Read-back returns 0..3 on the matching rsp_valid bits.
- Requester 2 holds req_valid continuously while requester 0 requests twice: grants alternate 2,0,2,0.
- Slave model never raises m_done:
  - rsp_valid with rsp_err=1 arrives TIMEOUT+1 cycles after WAIT entry.
  - The block stays busy in DRAIN until a forced m_done, then returns to IDLE.
- Assert rst in the WAIT state of a read:
  - All outputs go to 0 asynchronously.
  - No rsp_valid is produced, and the first grant after release goes to requester 0.
- Spurious m_done pulse in IDLE: no state change and no rsp_valid.
